// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with its dual-port RAM: pointers, accept gating, status flags and read-valid pipeline.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAG_EN is defined.
module sync_fifo_ctrl #(
  parameter int FIFO_DEPTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 8,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam ptr_t AF_TH = ptr_t'(ALMOST_FULL_TH);
  localparam ptr_t AE_TH = ptr_t'(ALMOST_EMPTY_TH);

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  logic  wr_acc;
  logic  rd_acc;

  // RAM-side port signals; both RAM clocks run on sys_clk.
  logic  ram_wr_port_ena;
  logic  ram_wr_en;
  addr_t ram_wr_addr;
  logic  ram_rd_port_ena;
  addr_t ram_rd_addr;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Accept gating and RAM port drive
  // ---------------------------------------------------------------------------
  assign wr_acc          = wr_en & ~full;
  assign rd_acc          = rd_en & ~empty;
  assign ram_wr_port_ena = wr_acc;
  assign ram_wr_en       = wr_acc;
  assign ram_wr_addr     = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_port_ena = rd_acc;
  assign ram_rd_addr     = rd_ptr[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Status decode from the registered pointers
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb block is assigned on every path so no latch is inferred.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    data_count   = wr_ptr - rd_ptr;
    almost_full  = (data_count >= AF_TH);
    almost_empty = (data_count <= AE_TH);
  end

  // ---------------------------------------------------------------------------
  // Pointers and read-valid pipeline
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ptr_t'(1);
      rd_valid <= rd_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Dual-port RAM: write port and registered read port
  // ---------------------------------------------------------------------------
  // NOTE: the storage array and its output register carry no reset; reset discards contents logically via the pointers.
  always_ff @(posedge sys_clk) begin
    if (ram_wr_port_ena && ram_wr_en) mem[ram_wr_addr] <= wr_data;
  end

  // Gating guarantees the read and write addresses never collide in one cycle.
  always_ff @(posedge sys_clk) begin
    if (ram_rd_port_ena) rd_data <= mem[ram_rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAG_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl: fill/drain, simultaneous access, wrap, async reset.
// Expected error-flag values follow whether FIFO_ERR_FLAG_EN is defined for the build.
module tb_sync_fifo_ctrl;

`ifdef FIFO_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [5:0] data_count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and return at the following falling edge for sampling.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, " empty"},        32'(empty),        32'd1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " full"},         32'(full),         32'd0);
    check({tag, " almost_full"},  32'(almost_full),  32'd0);
    check({tag, " data_count"},   32'(data_count),   32'd0);
    check({tag, " rd_valid"},     32'(rd_valid),     32'd0);
  endtask

  initial begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    apply_reset();

    // Reset state
    check_idle_state("reset");
    check("reset overflow",  32'(overflow),  32'd0);
    check("reset underflow", 32'(underflow), 32'd0);

    // 1. Fill 0x00..0x1F, then one dropped write while full
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      check($sformatf("fill count %0d", i), 32'(data_count), 32'(i + 1));
      check($sformatf("fill almost_full %0d", i), 32'(almost_full), 32'(i + 1 >= 28));
      check($sformatf("fill almost_empty %0d", i), 32'(almost_empty), 32'(i + 1 <= 4));
      check($sformatf("fill full %0d", i), 32'(full), 32'(i == 31));
      check($sformatf("fill empty %0d", i), 32'(empty), 32'd0);
    end
    check("fill no overflow yet", 32'(overflow), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0);
    check("ovf count", 32'(data_count), 32'd32);
    check("ovf full",  32'(full),       32'd1);
    check("ovf flag",  32'(overflow),   32'(ERR_EN));

    // 2. Drain; the first read carries a write that must be dropped because the FIFO is full
    cycle(1'b1, 8'hBB, 1'b1);
    check("drain0 rd_valid", 32'(rd_valid),   32'd1);
    check("drain0 rd_data",  32'(rd_data),    32'h00);
    check("drain0 count",    32'(data_count), 32'd31);
    for (int i = 1; i < 32; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check($sformatf("drain rd_valid %0d", i), 32'(rd_valid),   32'd1);
      check($sformatf("drain rd_data %0d", i),  32'(rd_data),    32'(i));
      check($sformatf("drain count %0d", i),    32'(data_count), 32'(31 - i));
    end
    check("drain empty", 32'(empty), 32'd1);
    check("drain no underflow yet", 32'(underflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("udf rd_valid", 32'(rd_valid),  32'd0);
    check("udf rd_data held", 32'(rd_data), 32'h1F);
    check("udf flag",     32'(underflow), 32'(ERR_EN));
    check("udf overflow sticky", 32'(overflow), 32'(ERR_EN));

    // 3. Simultaneous push/pop at count 10
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    check("simul start count", 32'(data_count), 32'd10);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'(8'h80 + k), 1'b1);
      check($sformatf("simul count %0d", k),    32'(data_count), 32'd10);
      check($sformatf("simul rd_valid %0d", k), 32'(rd_valid),   32'd1);
      check($sformatf("simul rd_data %0d", k),  32'(rd_data),    32'(8'h40 + k));
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check($sformatf("simul drain %0d", k), 32'(rd_data), (k < 5) ? 32'(8'h45 + k) : 32'(8'h80 + k - 5));
    end
    check("simul empty", 32'(empty), 32'd1);

    // 4. Wrap: three rounds of 20 writes then 20 reads
    apply_reset();
    check("wrap reset overflow",  32'(overflow),  32'd0);
    check("wrap reset underflow", 32'(underflow), 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'(r * 32 + i), 1'b0);
      check($sformatf("wrap%0d count", r), 32'(data_count), 32'd20);
      for (int i = 0; i < 20; i++) begin
        cycle(1'b0, 8'h00, 1'b1);
        check($sformatf("wrap%0d data %0d", r, i), 32'(rd_data), 32'(r * 32 + i));
      end
      check($sformatf("wrap%0d empty", r), 32'(empty), 32'd1);
      check($sformatf("wrap%0d full", r),  32'(full),  32'd0);
    end
    check("wrap overflow",  32'(overflow),  32'd0);
    check("wrap underflow", 32'(underflow), 32'd0);

    // 5. Read while empty with a concurrent write, then async reset at count 17
    cycle(1'b1, 8'h11, 1'b1);
    check("rwe rd_valid",  32'(rd_valid),   32'd0);
    check("rwe count",     32'(data_count), 32'd1);
    check("rwe underflow", 32'(underflow),  32'(ERR_EN));
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'h30, 1'b1);
    check("pre-rst count",    32'(data_count), 32'd17);
    check("pre-rst rd_valid", 32'(rd_valid),   32'd1);
    check("pre-rst rd_data",  32'(rd_data),    32'h11);
    #2 sys_rst = 1'b1;
    #1;
    check_idle_state("async rst");
    check("async rst overflow",  32'(overflow),  32'd0);
    check("async rst underflow", 32'(underflow), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cycle(1'b1, 8'h55, 1'b0);
    check("post-rst count", 32'(data_count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("post-rst rd_valid", 32'(rd_valid), 32'd1);
    check("post-rst rd_data",  32'(rd_data),  32'h55);
    check("post-rst empty",    32'(empty),    32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    check("idle rd_valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
